// File: rtl/fetch_if.sv
// Fetch stage port bundle: imem bus, hazard controls,
// BTB training pulse and the fetch/decode pipeline register.
interface fetch_if;
  logic        ihit;
  logic [31:0] imemload;
  logic [31:0] imemaddr;
  logic        imemREN;
  logic        freeze;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] fetch_imemload;
  logic [31:0] fetch_PC;
  logic [31:0] fetch_NPC;
  logic        fetch_branch_taken;
  logic [31:0] fetch_pred_branch_addr;

  modport master (
    input  ihit, imemload,
    input  freeze, flush, redirect_pc, halt,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    output imemaddr, imemREN,
    output fetch_imemload, fetch_PC, fetch_NPC,
    output fetch_branch_taken, fetch_pred_branch_addr
  );

  modport slave (
    output ihit, imemload,
    output freeze, flush, redirect_pc, halt,
    output upd_valid, upd_pc, upd_taken, upd_target,
    input  imemaddr, imemREN,
    input  fetch_imemload, fetch_PC, fetch_NPC,
    input  fetch_branch_taken, fetch_pred_branch_addr
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, direct-mapped BTB with
// 2-bit counters, and the fetch/decode pipeline register.
module fetch_stage #(
  parameter int unsigned BTB_ENTRIES = 8,
  parameter logic [31:0] PC_INIT     = 32'h0
) (
  input  logic    CLK,
  input  logic    nRST,
  fetch_if.master fif
);
  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW  = 30 - IDX;

  typedef struct packed {
    logic [31:0] imemload;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        taken;
    logic [31:0] pred;
  } if_id_t;

  logic [31:0] pc_q, pc_d;
  if_id_t      fr_q, fr_d;
  logic        halted_q, halted_d;

  logic          valid_q [BTB_ENTRIES];
  logic [TW-1:0] tag_q   [BTB_ENTRIES];
  logic [31:0]   tgt_q   [BTB_ENTRIES];
  logic [1:0]    ctr_q   [BTB_ENTRIES];

  logic [IDX-1:0] l_idx;
  logic [TW-1:0]  l_tag;
  logic           pred_taken;
  logic [31:0]    pc_plus4;
  logic [31:0]    pred_addr;
  logic [31:0]    next_pc;

  assign l_idx      = pc_q[IDX+1:2];
  assign l_tag      = pc_q[31:IDX+2];
  assign pred_taken = valid_q[l_idx]
                    & (tag_q[l_idx] == l_tag)
                    & ctr_q[l_idx][1];
  assign pc_plus4   = pc_q + 32'd4;
  assign pred_addr  = pred_taken ? tgt_q[l_idx] : 32'h0;
  assign next_pc    = pred_taken ? tgt_q[l_idx] : pc_plus4;

  assign fif.imemaddr = pc_q;
  assign fif.imemREN  = ~halted_q;

  assign fif.fetch_imemload         = fr_q.imemload;
  assign fif.fetch_PC               = fr_q.pc;
  assign fif.fetch_NPC              = fr_q.npc;
  assign fif.fetch_branch_taken     = fr_q.taken;
  assign fif.fetch_pred_branch_addr = fr_q.pred;

  assign halted_d = halted_q | fif.halt;

  // Halt outranks a redirect; a redirect outranks a stall.
  always_comb begin
    pc_d = pc_q;
    fr_d = fr_q;
    if (halted_q || fif.halt) begin
      pc_d = pc_q;
    end else if (fif.flush && fif.ihit) begin
      pc_d = fif.redirect_pc;
      fr_d = '0;
    end else if (fif.freeze) begin
      pc_d = pc_q;
    end else if (fif.ihit) begin
      pc_d          = next_pc;
      fr_d.imemload = fif.imemload;
      fr_d.pc       = pc_q;
      fr_d.npc      = pc_plus4;
      fr_d.taken    = pred_taken;
      fr_d.pred     = pred_addr;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q     <= PC_INIT;
      fr_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      fr_q     <= fr_d;
      halted_q <= halted_d;
    end
  end

  logic [IDX-1:0] u_idx;
  logic [TW-1:0]  u_tag;
  logic           u_match;
  logic           u_hit;
  logic           u_alloc;
  logic           u_we;
  logic [1:0]     u_ctr;
  logic [31:0]    u_tgt;
  logic           unused_upd_lsb;

  assign u_idx   = fif.upd_pc[IDX+1:2];
  assign u_tag   = fif.upd_pc[31:IDX+2];
  assign u_match = valid_q[u_idx] & (tag_q[u_idx] == u_tag);
  assign u_hit   = fif.upd_valid & u_match;
  assign u_alloc = fif.upd_valid & ~u_match & fif.upd_taken;
  assign unused_upd_lsb = ^fif.upd_pc[1:0];

  // A not-taken miss leaves the entry alone.
  always_comb begin
    u_we  = 1'b0;
    u_ctr = ctr_q[u_idx];
    u_tgt = tgt_q[u_idx];
    unique case (1'b1)
      u_hit: begin
        u_we = 1'b1;
        if (fif.upd_taken) begin
          u_tgt = fif.upd_target;
          if (ctr_q[u_idx] != 2'b11)
            u_ctr = ctr_q[u_idx] + 2'd1;
        end else if (ctr_q[u_idx] != 2'b00) begin
          u_ctr = ctr_q[u_idx] - 2'd1;
        end
      end
      u_alloc: begin
        u_we  = 1'b1;
        u_ctr = 2'b10;
        u_tgt = fif.upd_target;
      end
      default: u_we = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (u_we) begin
      valid_q[u_idx] <= 1'b1;
      tag_q[u_idx]   <= u_tag;
      tgt_q[u_idx]   <= u_tgt;
      ctr_q[u_idx]   <= u_ctr;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; fetched records go through
// a scoreboard queue and are checked one cycle later.
module tb_fetch_stage;
  logic CLK;
  logic nRST;
  int   checks;
  int   errors;

  typedef struct {
    logic [31:0] ld;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        tk;
    logic [31:0] pa;
  } exp_t;

  exp_t sbq[$];

  fetch_if fif ();

  fetch_stage #(
    .BTB_ENTRIES(8),
    .PC_INIT    (32'h0)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .fif (fif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_ld"},  fif.fetch_imemload, 32'h0);
    chk({tag, "_pc"},  fif.fetch_PC, 32'h0);
    chk({tag, "_npc"}, fif.fetch_NPC, 32'h0);
    chk({tag, "_tk"},  {31'h0, fif.fetch_branch_taken}, 32'h0);
    chk({tag, "_pa"},  fif.fetch_pred_branch_addr, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] ins,
                       input logic [31:0] pc,
                       input logic        tk,
                       input logic [31:0] pa);
    exp_t e;
    chk("imemaddr_pre", fif.imemaddr, pc);
    fif.ihit     = 1'b1;
    fif.imemload = ins;
    e = '{ins, pc, pc + 32'd4, tk, pa};
    sbq.push_back(e);
    cyc();
    fif.ihit = 1'b0;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sbq.pop_front();
      chk("fetch_imemload", fif.fetch_imemload, e.ld);
      chk("fetch_PC", fif.fetch_PC, e.pc);
      chk("fetch_NPC", fif.fetch_NPC, e.npc);
      chk("fetch_taken", {31'h0, fif.fetch_branch_taken},
          {31'h0, e.tk});
      chk("fetch_pred", fif.fetch_pred_branch_addr, e.pa);
    end
  endtask

  task automatic upd(input logic [31:0] pc,
                     input logic        tk,
                     input logic [31:0] tgt);
    fif.upd_valid  = 1'b1;
    fif.upd_pc     = pc;
    fif.upd_taken  = tk;
    fif.upd_target = tgt;
    cyc();
    fif.upd_valid = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    fif.flush       = 1'b1;
    fif.redirect_pc = pc;
    fif.ihit        = 1'b1;
    cyc();
    fif.flush = 1'b0;
    fif.ihit  = 1'b0;
    chk("redirect_addr", fif.imemaddr, pc);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRST            = 1'b0;
    fif.ihit        = 1'b0;
    fif.imemload    = 32'h0;
    fif.freeze      = 1'b0;
    fif.flush       = 1'b0;
    fif.redirect_pc = 32'h0;
    fif.halt        = 1'b0;
    fif.upd_valid   = 1'b0;
    fif.upd_pc      = 32'h0;
    fif.upd_taken   = 1'b0;
    fif.upd_target  = 32'h0;
    cyc();
    cyc();
    nRST = 1'b1;
    chk("rst_addr", fif.imemaddr, 32'h0);
    chk("rst_ren", {31'h0, fif.imemREN}, 32'h1);
    chk_bubble("rst");

    fetch(32'h20010001, 32'h0, 1'b0, 32'h0);
    fetch(32'h20020002, 32'h4, 1'b0, 32'h0);
    fetch(32'h20030003, 32'h8, 1'b0, 32'h0);

    repeat (3) begin
      cyc();
      chk("nohit_addr", fif.imemaddr, 32'hC);
      chk("nohit_pc", fif.fetch_PC, 32'h8);
    end
    fetch(32'h20040004, 32'hC, 1'b0, 32'h0);

    fif.freeze = 1'b1;
    fif.ihit   = 1'b1;
    repeat (2) begin
      cyc();
      chk("frz_addr", fif.imemaddr, 32'h10);
      chk("frz_pc", fif.fetch_PC, 32'hC);
      chk("frz_npc", fif.fetch_NPC, 32'h10);
    end
    fif.freeze = 1'b0;
    fif.ihit   = 1'b0;
    fetch(32'h20050005, 32'h10, 1'b0, 32'h0);

    fif.flush       = 1'b1;
    fif.redirect_pc = 32'h100;
    repeat (2) begin
      cyc();
      chk("flwait_addr", fif.imemaddr, 32'h14);
      chk("flwait_pc", fif.fetch_PC, 32'h10);
    end
    fif.ihit = 1'b1;
    cyc();
    fif.flush = 1'b0;
    fif.ihit  = 1'b0;
    chk("flush_addr", fif.imemaddr, 32'h100);
    chk_bubble("flush");

    fetch(32'h20060006, 32'h100, 1'b0, 32'h0);
    fif.freeze = 1'b1;
    redirect(32'h10);
    fif.freeze = 1'b0;
    chk_bubble("flfrz");

    upd(32'h10, 1'b1, 32'h40);
    fetch(32'h20070007, 32'h10, 1'b1, 32'h40);
    chk("btb_next", fif.imemaddr, 32'h40);

    upd(32'h10, 1'b0, 32'h0);
    redirect(32'h10);
    fetch(32'h20080008, 32'h10, 1'b0, 32'h0);
    chk("weak_next", fif.imemaddr, 32'h14);

    repeat (4) upd(32'h10, 1'b1, 32'h40);
    upd(32'h10, 1'b0, 32'h0);
    redirect(32'h10);
    fetch(32'h20090009, 32'h10, 1'b1, 32'h40);
    chk("sat_next", fif.imemaddr, 32'h40);

    upd(32'h30, 1'b1, 32'h80);
    redirect(32'h10);
    fetch(32'h200A000A, 32'h10, 1'b0, 32'h0);
    chk("alias_next", fif.imemaddr, 32'h14);
    redirect(32'h30);
    fetch(32'h200B000B, 32'h30, 1'b1, 32'h80);
    chk("alias30_next", fif.imemaddr, 32'h80);

    fif.upd_valid  = 1'b1;
    fif.upd_pc     = 32'h80;
    fif.upd_taken  = 1'b1;
    fif.upd_target = 32'h200;
    fetch(32'h200C000C, 32'h80, 1'b0, 32'h0);
    fif.upd_valid = 1'b0;
    chk("nobypass_next", fif.imemaddr, 32'h84);
    redirect(32'h80);
    fetch(32'h200D000D, 32'h80, 1'b1, 32'h200);
    chk("trained_next", fif.imemaddr, 32'h200);

    fif.halt        = 1'b1;
    fif.ihit        = 1'b1;
    fif.flush       = 1'b1;
    fif.redirect_pc = 32'h500;
    cyc();
    fif.halt = 1'b0;
    chk("halt_ren", {31'h0, fif.imemREN}, 32'h0);
    chk("halt_addr", fif.imemaddr, 32'h200);
    chk("halt_pc", fif.fetch_PC, 32'h80);
    repeat (10) begin
      cyc();
      chk("halted_ren", {31'h0, fif.imemREN}, 32'h0);
      chk("halted_addr", fif.imemaddr, 32'h200);
    end
    fif.ihit  = 1'b0;
    fif.flush = 1'b0;

    @(posedge CLK);
    #3;
    nRST = 1'b0;
    #1;
    chk("arst_addr", fif.imemaddr, 32'h0);
    chk("arst_ren", {31'h0, fif.imemREN}, 32'h1);
    chk_bubble("arst");
    #2;
    nRST = 1'b1;
    cyc();
    fetch(32'h200E000E, 32'h0, 1'b0, 32'h0);
    chk("post_rst_next", fif.imemaddr, 32'h4);
    chk("sb_drained", sbq.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
